// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with registered reads and write-first bypass.
// Define ZERO_REG_EN to hardwire register 0 to zero.
module regfile_2r1w #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              We,
  input  logic [ADDR_W-1:0] Waddr,
  input  logic [WIDTH-1:0]  Wdata,
  input  logic              Rd_en_a,
  input  logic [ADDR_W-1:0] Raddr_a,
  output logic [WIDTH-1:0]  Rdata_a,
  input  logic              Rd_en_b,
  input  logic [ADDR_W-1:0] Raddr_b,
  output logic [WIDTH-1:0]  Rdata_b,
  output logic              Rvalid_a,
  output logic              Rvalid_b
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_rdata_a;
  logic [WIDTH-1:0]  r_rdata_b;
  logic              r_rvalid_a;
  logic              r_rvalid_b;

  logic [ADDR_W:0]   w_waddr_ext;
  logic [ADDR_W:0]   w_raddr_a_ext;
  logic [ADDR_W:0]   w_raddr_b_ext;
  logic              w_wr_ok;
  logic              w_ra_ok;
  logic              w_rb_ok;
  logic [WIDTH-1:0]  w_rd_a;
  logic [WIDTH-1:0]  w_rd_b;
  logic [WIDTH-1:0]  w_nxt_a;
  logic [WIDTH-1:0]  w_nxt_b;

  assign w_waddr_ext   = {1'b0, Waddr};
  assign w_raddr_a_ext = {1'b0, Raddr_a};
  assign w_raddr_b_ext = {1'b0, Raddr_b};

  assign w_ra_ok = (w_raddr_a_ext < LP_DEPTH);
  assign w_rb_ok = (w_raddr_b_ext < LP_DEPTH);

  // Writes to address 0 are discarded when it is the zero register.
`ifdef ZERO_REG_EN
  assign w_wr_ok = We && (w_waddr_ext < LP_DEPTH)
                   && (Waddr != '0);
`else
  assign w_wr_ok = We && (w_waddr_ext < LP_DEPTH);
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (Waddr == ADDR_W'(i)) begin
          r_mem[i] <= Wdata;
        end
      end
    end
  end

  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Raddr_a == ADDR_W'(i)) begin
        w_rd_a = r_mem[i];
      end
      if (Raddr_b == ADDR_W'(i)) begin
        w_rd_b = r_mem[i];
      end
    end
  end

  // Priority: out of range, zero register, bypass, storage.
  always_comb begin
    w_nxt_a = w_rd_a;
    if (!w_ra_ok) begin
      w_nxt_a = '0;
`ifdef ZERO_REG_EN
    end else if (Raddr_a == '0) begin
      w_nxt_a = '0;
`endif
    end else if (w_wr_ok && (Waddr == Raddr_a)) begin
      w_nxt_a = Wdata;
    end
  end

  always_comb begin
    w_nxt_b = w_rd_b;
    if (!w_rb_ok) begin
      w_nxt_b = '0;
`ifdef ZERO_REG_EN
    end else if (Raddr_b == '0) begin
      w_nxt_b = '0;
`endif
    end else if (w_wr_ok && (Waddr == Raddr_b)) begin
      w_nxt_b = Wdata;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rdata_a  <= '0;
      r_rvalid_a <= 1'b0;
    end else begin
      r_rvalid_a <= Rd_en_a;
      if (Rd_en_a) begin
        r_rdata_a <= w_nxt_a;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_rdata_b  <= '0;
      r_rvalid_b <= 1'b0;
    end else begin
      r_rvalid_b <= Rd_en_b;
      if (Rd_en_b) begin
        r_rdata_b <= w_nxt_b;
      end
    end
  end

  assign Rdata_a  = r_rdata_a;
  assign Rdata_b  = r_rdata_b;
  assign Rvalid_a = r_rvalid_a;
  assign Rvalid_b = r_rvalid_b;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: a 32-deep and a 24-deep instance share stimulus.
// Table vectors carry hand-derived results; scans use a behavioural model.
module tb_regfile_2r1w;

  typedef struct {
    logic [31:0] a;
    logic        va;
    logic [31:0] b;
    logic        vb;
  } exp_t;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ea;
    logic [4:0]  ra;
    logic        eb;
    logic [4:0]  rb;
    exp_t        e;
  } vec_t;

`ifdef ZERO_REG_EN
  localparam logic [31:0] ZV = 32'h0;
  localparam bit ZEN = 1'b1;
`else
  localparam logic [31:0] ZV = 32'hA5A5A5A5;
  localparam bit ZEN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ea, eb;
  logic [4:0]  ra, rb;
  logic [31:0] rda0, rdb0, rda1, rdb1;
  logic        rva0, rvb0, rva1, rvb1;

  int n_tests;
  int n_fail;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic [31:0] pa [2];
  logic [31:0] pb [2];
  exp_t q0 [$];
  exp_t q1 [$];
  vec_t tab [13];

  regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) u_d32 (
    .Clk(clk), .Rst_n(rst_n), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Rd_en_a(ea), .Raddr_a(ra), .Rdata_a(rda0),
    .Rd_en_b(eb), .Raddr_b(rb), .Rdata_b(rdb0),
    .Rvalid_a(rva0), .Rvalid_b(rvb0)
  );

  regfile_2r1w #(.WIDTH(32), .DEPTH(24), .ADDR_W(5)) u_d24 (
    .Clk(clk), .Rst_n(rst_n), .We(we), .Waddr(waddr), .Wdata(wdata),
    .Rd_en_a(ea), .Raddr_a(ra), .Rdata_a(rda1),
    .Rd_en_b(eb), .Raddr_b(rb), .Rdata_b(rdb1),
    .Rvalid_a(rva1), .Rvalid_b(rvb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mget(input int d, input int i);
    return (d == 0) ? m0[i] : m1[i];
  endfunction

  function automatic logic [31:0] mrd(input int d, input int dep,
                                      input int adr);
    if (adr >= dep) return 32'h0;
    if (ZEN && adr == 0) return 32'h0;
    if (we && int'(waddr) == adr) return wdata;
    return mget(d, adr);
  endfunction

  task automatic mclear();
    for (int i = 0; i < 32; i++) begin
      m0[i] = '0;
      m1[i] = '0;
    end
    for (int d = 0; d < 2; d++) begin
      pa[d] = '0;
      pb[d] = '0;
    end
  endtask

  task automatic mexp(input int d, input int dep, output exp_t e);
    e.va = ea;
    e.vb = eb;
    e.a  = ea ? mrd(d, dep, int'(ra)) : pa[d];
    e.b  = eb ? mrd(d, dep, int'(rb)) : pb[d];
    pa[d] = e.a;
    pb[d] = e.b;
  endtask

  task automatic mwrite();
    if (we && !(ZEN && waddr == 5'd0)) begin
      m0[waddr] = wdata;
      if (int'(waddr) < 24) m1[waddr] = wdata;
    end
  endtask

  task automatic pop_chk(input string tag);
    exp_t e;
    if (q0.size() == 0 || q1.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", tag);
      return;
    end
    e = q0.pop_front();
    chk({tag, " d32 rdata_a"}, rda0, e.a);
    chk({tag, " d32 rvalid_a"}, {31'b0, rva0}, {31'b0, e.va});
    chk({tag, " d32 rdata_b"}, rdb0, e.b);
    chk({tag, " d32 rvalid_b"}, {31'b0, rvb0}, {31'b0, e.vb});
    e = q1.pop_front();
    chk({tag, " d24 rdata_a"}, rda1, e.a);
    chk({tag, " d24 rvalid_a"}, {31'b0, rva1}, {31'b0, e.va});
    chk({tag, " d24 rdata_b"}, rdb1, e.b);
    chk({tag, " d24 rvalid_b"}, {31'b0, rvb1}, {31'b0, e.vb});
  endtask

  task automatic step(input vec_t v, input bit use_tab, input string tag);
    exp_t e0, e1;
    @(negedge clk);
    we = v.we; waddr = v.wa; wdata = v.wd;
    ea = v.ea; ra = v.ra; eb = v.eb; rb = v.rb;
    mexp(0, 32, e0);
    mexp(1, 24, e1);
    if (use_tab) begin
      e0 = v.e;
      pa[0] = v.e.a;
      pb[0] = v.e.b;
    end
    q0.push_back(e0);
    q1.push_back(e1);
    mwrite();
    @(posedge clk);
    #1;
    pop_chk(tag);
  endtask

  function automatic vec_t mk(input logic w, input int wa,
      input logic [31:0] wd, input logic a_en, input int a,
      input logic b_en, input int b, input logic [31:0] xa,
      input logic xva, input logic [31:0] xb, input logic xvb);
    vec_t v;
    v.we = w; v.wa = 5'(wa); v.wd = wd;
    v.ea = a_en; v.ra = 5'(a); v.eb = b_en; v.rb = 5'(b);
    v.e.a = xa; v.e.va = xva; v.e.b = xb; v.e.vb = xvb;
    return v;
  endfunction

  task automatic scan(input int n, input string tag);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v = mk(1'b0, 0, 32'h0, 1'b1, i, 1'b1, n - 1 - i,
             32'h0, 1'b0, 32'h0, 1'b0);
      step(v, 1'b0, $sformatf("%s[%0d]", tag, i));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " d32 rdata_a"}, rda0, 32'h0);
    chk({tag, " d32 rdata_b"}, rdb0, 32'h0);
    chk({tag, " d32 rvalid"}, {30'b0, rva0, rvb0}, 32'h0);
    chk({tag, " d24 rdata_a"}, rda1, 32'h0);
    chk({tag, " d24 rdata_b"}, rdb1, 32'h0);
    chk({tag, " d24 rvalid"}, {30'b0, rva1, rvb1}, 32'h0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    ea = 1'b0; ra = '0; eb = 1'b0; rb = '0;
    mclear();

    tab[0]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  0, 0,
                 32'h0, 0, 32'h0, 0);
    tab[1]  = mk(0, 0,  32'h0,        1, 5,  1, 6,
                 32'hDEADBEEF, 1, 32'h0, 1);
    tab[2]  = mk(1, 7,  32'h1234,     1, 7,  1, 7,
                 32'h1234, 1, 32'h1234, 1);
    tab[3]  = mk(0, 0,  32'h0,        0, 0,  0, 0,
                 32'h1234, 0, 32'h1234, 0);
    tab[4]  = mk(1, 9,  32'h111,      1, 5,  0, 0,
                 32'hDEADBEEF, 1, 32'h1234, 0);
    tab[5]  = mk(1, 9,  32'h222,      0, 0,  1, 9,
                 32'hDEADBEEF, 0, 32'h222, 1);
    tab[6]  = mk(0, 0,  32'h0,        1, 9,  1, 9,
                 32'h222, 1, 32'h222, 1);
    tab[7]  = mk(1, 30, 32'hFFFF,     1, 30, 0, 0,
                 32'hFFFF, 1, 32'h222, 0);
    tab[8]  = mk(0, 0,  32'h0,        1, 30, 1, 0,
                 32'hFFFF, 1, 32'h0, 1);
    tab[9]  = mk(1, 0,  32'hA5A5A5A5, 1, 0,  1, 5,
                 ZV, 1, 32'hDEADBEEF, 1);
    tab[10] = mk(0, 0,  32'h0,        1, 0,  1, 30,
                 ZV, 1, 32'hFFFF, 1);
    tab[11] = mk(1, 31, 32'hCAFEF00D, 0, 0,  0, 0,
                 ZV, 0, 32'hFFFF, 0);
    tab[12] = mk(0, 0,  32'h0,        1, 31, 1, 1,
                 32'hCAFEF00D, 1, 32'h0, 1);

    #12;
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    scan(32, "post_reset");

    for (int i = 0; i < 13; i++) begin
      step(tab[i], 1'b1, $sformatf("vec%0d", i));
    end

    scan(32, "full_scan");

    step(mk(1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "fill3");
    step(mk(1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "fill4");
    step(mk(0, 0, 32'h0, 1, 3, 1, 4, 0, 0, 0, 0), 1'b0, "pre_rst");

    @(negedge clk);
    we = 1'b0; ea = 1'b1; ra = 5'd3; eb = 1'b1; rb = 5'd4;
    rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    mclear();
    @(negedge clk);
    chk_zero("held_reset");
    ea = 1'b0; eb = 1'b0;
    rst_n = 1'b1;

    scan(32, "after_reset");

    if (q0.size() != 0 || q1.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left", q0.size() + q1.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
